trenc_atb_sched: RTL and testbench
==================================

TRENC_ATB_SCHED -- requirements
Module: trenc_atb_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, giving the number of core packet requesters.
REQ-002 SHALL have parameter PKT_W, default PKTDATA_LEN (160), giving the packet data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port cfg_enable, input, 1, the teEnable control: grants new packets when high.
REQ-006 SHALL have port pkt_valid, input, NUM_PORTS, per-port packet available.
REQ-007 SHALL have port pkt_ready, output, NUM_PORTS, per-port packet accepted.
REQ-008 SHALL have port pkt_data, input, NUM_PORTS x PKT_W, per-port packet payload, LSB-first.
REQ-009 SHALL have port pkt_len, input, NUM_PORTS x 8, per-port packet length in bits.
REQ-010 SHALL have port atvalid, output, 1, ATB beat valid.
REQ-011 SHALL have port atready, input, 1, ATB sink ready.
REQ-012 SHALL have port atdata, output, ATBWIDTH (64), ATB beat data.
REQ-013 SHALL have port atid, output, 7, trace source ID.
REQ-014 SHALL have port atbytes, output, 3, number of valid bytes minus 1.
REQ-015 SHALL have port afvalid, input, 1, ATB flush request.
REQ-016 SHALL have port afready, output, 1, flush complete.
REQ-017 SHALL have port busy, output, 1, high while a packet is in flight.

Function
REQ-018 SHALL implement FSM arb_state_t with states IDLE and SEND.
REQ-019 In IDLE with cfg_enable=1 and any pkt_valid set, SHALL grant exactly one port by round-robin, pulse its pkt_ready for 1 cycle, capture pkt_data/pkt_len/port index, and go to SEND.
REQ-020 Round-robin pointer SHALL reset to 0; after a grant to port i it SHALL become (i+1) mod NUM_PORTS; search order SHALL be pointer, pointer+1, ... with wrap-around.
REQ-021 A pkt_len of 0 SHALL be accepted and discarded: no beats, stay IDLE, pointer still advances.
REQ-022 A pkt_len greater than PKT_W SHALL be clamped to PKT_W.
REQ-023 Beat count SHALL be ceil(len/64), range 1..3; beat k SHALL carry captured data bits [64k+63:64k].
REQ-024 atvalid SHALL rise the cycle after acceptance, giving 1-cycle latency.
REQ-025 atdata, atid and atbytes SHALL stay stable while atvalid=1 and atready=0.
REQ-026 A beat SHALL transfer on atvalid and atready both high.
REQ-027 atbytes SHALL be 7 on non-last beats; on the last beat, with r the remaining bits (1..64), it SHALL be ceil(r/8)-1.
REQ-028 atid SHALL be TR_ATBID_CORE0..3 for captured port 0..3.
REQ-029 On last-beat transfer the FSM SHALL return to IDLE; this gives one bubble cycle between packets.
REQ-030 cfg_enable falling mid-packet SHALL NOT abort the packet; remaining beats SHALL complete, then no new grants.
REQ-031 afready SHALL be asserted combinationally when afvalid=1 and the state is IDLE.
REQ-032 A flush in SEND SHALL hold afready low until the packet completes.
REQ-033 Simultaneous afvalid and a pending grant in IDLE SHALL take the grant first, so afready stays low that cycle.
REQ-034 Non-granted pkt_valid inputs SHALL be held with no ready; data SHALL never be dropped except per REQ-021.
REQ-035 busy SHALL equal (state==SEND).

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE, pointer=0, beat counter=0, atvalid=0, atdata=0, atid=0, atbytes=0, pkt_ready=0, afready=0, busy=0.
REQ-037 Reset mid-packet SHALL drop the in-flight packet without completing it.
REQ-038 First grant SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-039 The shared package trenc_pkg SHALL hold arb_state_t, the ATB ID lookup array of TR_ATBID_CORE0..3, and BEAT_CNT_W=2.
REQ-040 Round-robin grant logic SHALL be sub-module trenc_rr_arb (req, ptr -> one-hot gnt, gnt_idx).
REQ-041 The capture register SHALL be the only packet storage; there SHALL be no FIFO.

Verification
REQ-042 Port1 valid, len=82, atready=1 -> 2 beats, atid=0x1F, atbytes 7 then 2, pkt_ready pulse 1 cycle.
REQ-043 All 4 ports valid continuously, len=64 -> grant order 0,1,2,3,0, each packet 1 beat atbytes=7, 1 bubble cycle apart.
REQ-044 Port2 len=160, atready low 5 cycles on beat 1 -> atdata/atid/atbytes stable, 3 beats total, last atbytes=3.
REQ-045 Port0 len=0 then port3 len=200 -> no beats for port0; port3 sends 3 beats with atid=0x3F, final atbytes=3.
REQ-046 afvalid asserted mid-SEND, cfg_enable dropped -> packet completes, afready high the next IDLE cycle, no further grants.
REQ-047 rst_n pulsed low during beat 2 -> outputs 0 immediately, pointer 0, next grant to lowest valid port.

Source files
------------

// File: rtl/trenc_pkg.sv
// Shared types and constants for the trace-encoder ATB scheduler.
// Holds the arbiter state type, the per-core ATB source IDs and beat counter width.
package trenc_pkg;

  localparam int PKTDATA_LEN = 160;
  localparam int ATBWIDTH    = 64;
  localparam int BEAT_CNT_W  = 2;

  localparam logic [6:0] TR_ATBID_CORE0 = 7'h0F;
  localparam logic [6:0] TR_ATBID_CORE1 = 7'h1F;
  localparam logic [6:0] TR_ATBID_CORE2 = 7'h2F;
  localparam logic [6:0] TR_ATBID_CORE3 = 7'h3F;

  // Indexed by captured port number: element [0] is core 0.
  localparam logic [3:0][6:0] TR_ATBID_LUT = {TR_ATBID_CORE3, TR_ATBID_CORE2,
                                              TR_ATBID_CORE1, TR_ATBID_CORE0};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

endpackage

// File: rtl/trenc_atb_sched_rr_arb.sv
// Round-robin requester selection: first set request at or after the pointer, wrapping.
// Purely combinational; the caller owns the pointer register.
module trenc_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/trenc_atb_sched.sv
// Schedules per-core trace packets onto a single ATB master, one packet at a time.
// A granted packet is captured whole and streamed out as 64-bit beats.
//
//   state | meaning
//   IDLE  | no packet held; may grant a requester or acknowledge a flush
//   SEND  | captured packet being emitted beat by beat on ATB
module trenc_atb_sched
  import trenc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PKT_W     = PKTDATA_LEN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_enable,
  input  logic [NUM_PORTS-1:0]             pkt_valid,
  output logic [NUM_PORTS-1:0]             pkt_ready,
  input  logic [NUM_PORTS-1:0][PKT_W-1:0]  pkt_data,
  input  logic [NUM_PORTS-1:0][7:0]        pkt_len,
  output logic                             atvalid,
  input  logic                             atready,
  output logic [ATBWIDTH-1:0]              atdata,
  output logic [6:0]                       atid,
  output logic [2:0]                       atbytes,
  input  logic                             afvalid,
  output logic                             afready,
  output logic                             busy
);

  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MAX_BEATS = (PKT_W + ATBWIDTH - 1) / ATBWIDTH;
  localparam int CAP_W     = MAX_BEATS * ATBWIDTH;

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
  logic [BEAT_CNT_W-1:0]   last_beat_q, last_beat_d;
  logic [2:0]              last_bytes_q, last_bytes_d;
  logic [CAP_W-1:0]        data_q, data_d;
  logic                    atvalid_q, atvalid_d;
  logic [6:0]              atid_q, atid_d;
  logic [2:0]              atbytes_q, atbytes_d;

  logic [NUM_PORTS-1:0]    gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic                    grant;
  logic [7:0]              len_c;
  logic [7:0]              len_m1;
  logic                    xfer;
  logic                    last_xfer;

  trenc_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_arb (
    .req_i     (pkt_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // rst_n gates the combinational handshakes so nothing is acknowledged during reset.
  assign grant     = rst_n && (state_q == IDLE) && cfg_enable && gnt_any;
  assign pkt_ready = grant ? gnt : '0;
  assign afready   = rst_n && afvalid && (state_q == IDLE) && !grant;

  assign len_c     = (pkt_len[gnt_idx] > 8'(PKT_W)) ? 8'(PKT_W) : pkt_len[gnt_idx];
  assign len_m1    = len_c - 8'd1;
  assign xfer      = atvalid_q && atready;
  assign last_xfer = xfer && (beat_q == last_beat_q);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    last_beat_d  = last_beat_q;
    last_bytes_d = last_bytes_q;
    data_d       = data_q;
    atvalid_d    = atvalid_q;
    atid_d       = atid_q;
    atbytes_d    = atbytes_q;

    if (grant) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Zero-length packets are acknowledged but never leave IDLE.
        if (grant && (len_c != 8'd0)) begin
          state_d      = SEND;
          atvalid_d    = 1'b1;
          beat_d       = '0;
          last_beat_d  = BEAT_CNT_W'(len_m1 >> 6);
          last_bytes_d = len_m1[5:3];
          data_d       = CAP_W'(pkt_data[gnt_idx]);
          atid_d       = TR_ATBID_LUT[2'(gnt_idx)];
          atbytes_d    = (len_m1[7:6] == 2'b00) ? len_m1[5:3] : 3'd7;
        end
      end
      SEND: begin
        if (last_xfer) begin
          state_d   = IDLE;
          atvalid_d = 1'b0;
          beat_d    = '0;
        end else if (xfer) begin
          beat_d    = beat_q + 1'b1;
          data_d    = data_q >> ATBWIDTH;
          atbytes_d = (beat_d == last_beat_q) ? last_bytes_q : 3'd7;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      beat_q       <= '0;
      last_beat_q  <= '0;
      last_bytes_q <= '0;
      data_q       <= '0;
      atvalid_q    <= 1'b0;
      atid_q       <= '0;
      atbytes_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      beat_q       <= beat_d;
      last_beat_q  <= last_beat_d;
      last_bytes_q <= last_bytes_d;
      data_q       <= data_d;
      atvalid_q    <= atvalid_d;
      atid_q       <= atid_d;
      atbytes_q    <= atbytes_d;
    end
  end

  assign atvalid = atvalid_q;
  assign atdata  = data_q[ATBWIDTH-1:0];
  assign atid    = atid_q;
  assign atbytes = atbytes_q;
  assign busy    = (state_q == SEND);

endmodule

// File: tb/tb_trenc_atb_sched.sv
// Directed bench for trenc_atb_sched: grant order, beat split, stalls, flush and reset.
module tb_trenc_atb_sched;

  logic                   clk;
  logic                   rst_n;
  logic                   cfg_enable;
  logic [3:0]             pkt_valid;
  logic [3:0]             pkt_ready;
  logic [3:0][159:0]      pkt_data;
  logic [3:0][7:0]        pkt_len;
  logic                   atvalid;
  logic                   atready;
  logic [63:0]            atdata;
  logic [6:0]             atid;
  logic [2:0]             atbytes;
  logic                   afvalid;
  logic                   afready;
  logic                   busy;

  int n_chk;
  int n_fail;

  trenc_atb_sched #(
    .NUM_PORTS (4),
    .PKT_W     (160)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_enable (cfg_enable),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .pkt_len    (pkt_len),
    .atvalid    (atvalid),
    .atready    (atready),
    .atdata     (atdata),
    .atid       (atid),
    .atbytes    (atbytes),
    .afvalid    (afvalid),
    .afready    (afready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // One packet: grant cycle, then every beat (optionally stalling one beat).
  task automatic do_pkt(input string tag, input logic [3:0] vmask, input logic [3:0] hold,
                        input int port, input logic [7:0] len, input logic [6:0] exp_id,
                        input int exp_nb, input logic [2:0] exp_lastb,
                        input int stall_beat, input int stall_n);
    logic [191:0] d;
    int           ns;
    d = {32'h0, pkt_data[port]};
    @(negedge clk);
    pkt_len[port] = len;
    pkt_valid     = vmask;
    atready       = 1'b1;
    #1;
    chk({tag, ".grant"}, pkt_ready, 4'b0001 << port);
    chk({tag, ".bubble"}, {atvalid, busy}, 2'b00);
    for (int k = 0; k < exp_nb; k++) begin
      ns = (k == stall_beat) ? stall_n : 0;
      for (int s = 0; s <= ns; s++) begin
        @(negedge clk);
        pkt_valid = hold;
        atready   = (s < ns) ? 1'b0 : 1'b1;
        #1;
        chk($sformatf("%s.b%0d.vld", tag, k), {atvalid, busy}, 2'b11);
        chk($sformatf("%s.b%0d.data", tag, k), atdata, d[k*64 +: 64]);
        chk($sformatf("%s.b%0d.id", tag, k), atid, exp_id);
        chk($sformatf("%s.b%0d.bytes", tag, k), atbytes,
            (k == exp_nb - 1) ? exp_lastb : 3'd7);
        chk($sformatf("%s.b%0d.noready", tag, k), pkt_ready, 4'b0000);
      end
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    cfg_enable = 1'b1;
    pkt_valid  = 4'hF;
    atready    = 1'b1;
    afvalid    = 1'b1;
    pkt_len    = '0;
    for (int p = 0; p < 4; p++) begin
      pkt_data[p] = {32'hE000_0000 | 32'(p), 64'hB1B2_B3B4_B5B6_B700 | 64'(p),
                     64'hA1A2_A3A4_A5A6_A700 | 64'(p)};
    end

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.atvalid", atvalid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.atdata", atdata, 64'h0);
    chk("rst.atid", atid, 7'h0);
    chk("rst.atbytes", atbytes, 3'h0);
    chk("rst.pkt_ready", pkt_ready, 4'h0);
    chk("rst.afready", afready, 1'b0);
    pkt_valid = 4'h0;
    afvalid   = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Port 1, 82 bits, granted in the first cycle out of reset.
    do_pkt("p1_82", 4'b0010, 4'b0000, 1, 8'd82, 7'h1F, 2, 3'd2, -1, 0);
    // Port 2, full 160 bits, sink stalls beat 1 for 5 cycles.
    do_pkt("p2_160", 4'b0100, 4'b0000, 2, 8'd160, 7'h2F, 3, 3'd3, 1, 5);
    // Zero-length packet on port 0: acknowledged, no beats, pointer moves to 1.
    do_pkt("p0_len0", 4'b0001, 4'b0000, 0, 8'd0, 7'h0F, 0, 3'd0, -1, 0);
    do_pkt("p0p1", 4'b0011, 4'b0001, 1, 8'd64, 7'h1F, 1, 3'd7, -1, 0);
    // Port 0 was held without ready and is served next.
    do_pkt("p0_held", 4'b0001, 4'b0000, 0, 8'd8, 7'h0F, 1, 3'd0, -1, 0);
    // Oversize length clamps to 160.
    do_pkt("p3_200", 4'b1000, 4'b0000, 3, 8'd200, 7'h3F, 3, 3'd3, -1, 0);

    do_pkt("rr0", 4'hF, 4'hF, 0, 8'd64, 7'h0F, 1, 3'd7, -1, 0);
    do_pkt("rr1", 4'hF, 4'hF, 1, 8'd64, 7'h1F, 1, 3'd7, -1, 0);
    do_pkt("rr2", 4'hF, 4'hF, 2, 8'd64, 7'h2F, 1, 3'd7, -1, 0);
    do_pkt("rr3", 4'hF, 4'hF, 3, 8'd64, 7'h3F, 1, 3'd7, -1, 0);
    do_pkt("rr4", 4'hF, 4'hF, 0, 8'd64, 7'h0F, 1, 3'd7, -1, 0);
    @(negedge clk);
    pkt_valid = 4'h0;
    #1;
    chk("rr.end.atvalid", atvalid, 1'b0);
    chk("rr.end.ready", pkt_ready, 4'h0);

    // Flush during a packet with enable dropped; grant wins over flush in IDLE.
    @(negedge clk);
    pkt_valid  = 4'b0010;
    pkt_len[1] = 8'd160;
    afvalid    = 1'b1;
    #1;
    chk("fl.grant", pkt_ready, 4'b0010);
    chk("fl.af_vs_grant", afready, 1'b0);
    @(negedge clk);
    pkt_valid  = 4'hF;
    cfg_enable = 1'b0;
    #1;
    chk("fl.b0.vld", atvalid, 1'b1);
    chk("fl.b0.af", afready, 1'b0);
    @(negedge clk);
    #1;
    chk("fl.b1.bytes", atbytes, 3'd7);
    chk("fl.b1.af", afready, 1'b0);
    @(negedge clk);
    #1;
    chk("fl.b2.vld", {atvalid, busy}, 2'b11);
    chk("fl.b2.bytes", atbytes, 3'd3);
    chk("fl.b2.af", afready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("fl.idle%0d.vld", c), {atvalid, busy}, 2'b00);
      chk($sformatf("fl.idle%0d.af", c), afready, 1'b1);
      chk($sformatf("fl.idle%0d.ready", c), pkt_ready, 4'h0);
    end

    // Reset in the middle of beat 2 of a port-2 packet.
    @(negedge clk);
    afvalid    = 1'b0;
    cfg_enable = 1'b1;
    pkt_valid  = 4'b0100;
    pkt_len[2] = 8'd160;
    #1;
    chk("mr.grant", pkt_ready, 4'b0100);
    @(negedge clk);
    pkt_valid = 4'h0;
    #1;
    chk("mr.b0.vld", atvalid, 1'b1);
    @(negedge clk);
    #1;
    chk("mr.b1.vld", atvalid, 1'b1);
    #2;
    pkt_valid = 4'b1010;
    afvalid   = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mr.atvalid", atvalid, 1'b0);
    chk("mr.busy", busy, 1'b0);
    chk("mr.atdata", atdata, 64'h0);
    chk("mr.atid", atid, 7'h0);
    chk("mr.atbytes", atbytes, 3'h0);
    chk("mr.pkt_ready", pkt_ready, 4'h0);
    chk("mr.afready", afready, 1'b0);
    afvalid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    // Pointer is back at 0, so the lowest valid port (1) wins over port 3.
    do_pkt("mr.next", 4'b1010, 4'b0000, 1, 8'd64, 7'h1F, 1, 3'd7, -1, 0);
    @(negedge clk);
    pkt_valid = 4'h0;
    #1;
    chk("mr.end.atvalid", atvalid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
